// File: rtl/control_command_tx_pkg.sv
// Shared definitions for the control-unit command transmitter:
// command codes, frame field-mask bits and TX state encodings.
package control_command_tx_pkg;

    // Default instruction field width, matching the control unit's BLOCK_INSTR_WIDTH.
    localparam int BLOCK_INSTR_WIDTH = 32;

    // Command codes understood by the control unit.
    localparam logic [7:0] COMMAND_WRITE_BLOCK_INSTR  = 8'h01;
    localparam logic [7:0] COMMAND_WRITE_BLOCK_REG    = 8'h02;
    localparam logic [7:0] COMMAND_UPDATE_BLOCK_REG   = 8'h03;
    localparam logic [7:0] COMMAND_COMMIT_REG_UPDATES = 8'h04;
    localparam logic [7:0] COMMAND_ALLOC_DELAY        = 8'h05;
    localparam logic [7:0] COMMAND_SWAP_PIPELINES     = 8'h06;
    localparam logic [7:0] COMMAND_RESET_PIPELINE     = 8'h07;
    localparam logic [7:0] COMMAND_SET_INPUT_GAIN     = 8'h08;
    localparam logic [7:0] COMMAND_SET_OUTPUT_GAIN    = 8'h09;

    // Field-mask bit positions; the command byte is always present and has no bit.
    localparam int TX_FIELD_BLOCK = 0;
    localparam int TX_FIELD_REG   = 1;
    localparam int TX_FIELD_DATA  = 2;
    localparam int TX_FIELD_INSTR = 3;
    localparam int TX_FIELD_DELAY = 4;
    localparam int TX_FIELD_W     = 5;

    typedef logic [TX_FIELD_W-1:0] tx_mask_t;

    // Transmitter states.
    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_LOAD = 2'd1,
        TX_SEND = 2'd2,
        TX_GAP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/command_frame_layout.sv
// Combinational frame-layout decoder: command byte -> field mask,
// total byte count (including the command byte) and a valid flag.
module command_frame_layout
    import control_command_tx_pkg::*;
#(
    parameter int data_width  = 16,
    parameter int instr_width = BLOCK_INSTR_WIDTH
) (
    input  logic [7:0] command_i,
    output tx_mask_t   mask_o,
    output logic [7:0] n_total_o,
    output logic       valid_o
);

    localparam int DATA_B  = data_width / 8;
    localparam int INSTR_B = instr_width / 8;

    // Decode which fields follow the command byte and how many bytes the frame holds.
    always_comb begin
        mask_o    = '0;
        n_total_o = 8'd0;
        valid_o   = 1'b0;
        case (command_i)
            COMMAND_COMMIT_REG_UPDATES,
            COMMAND_SWAP_PIPELINES,
            COMMAND_RESET_PIPELINE: begin
                n_total_o = 8'd1;
                valid_o   = 1'b1;
            end
            COMMAND_WRITE_BLOCK_INSTR: begin
                mask_o[TX_FIELD_BLOCK] = 1'b1;
                mask_o[TX_FIELD_INSTR] = 1'b1;
                n_total_o = 8'(2 + INSTR_B);
                valid_o   = 1'b1;
            end
            COMMAND_WRITE_BLOCK_REG,
            COMMAND_UPDATE_BLOCK_REG: begin
                mask_o[TX_FIELD_BLOCK] = 1'b1;
                mask_o[TX_FIELD_REG]   = 1'b1;
                mask_o[TX_FIELD_DATA]  = 1'b1;
                n_total_o = 8'(3 + DATA_B);
                valid_o   = 1'b1;
            end
            COMMAND_ALLOC_DELAY: begin
                mask_o[TX_FIELD_DATA]  = 1'b1;
                mask_o[TX_FIELD_DELAY] = 1'b1;
                n_total_o = 8'(5 + DATA_B);
                valid_o   = 1'b1;
            end
            COMMAND_SET_INPUT_GAIN,
            COMMAND_SET_OUTPUT_GAIN: begin
                mask_o[TX_FIELD_DATA] = 1'b1;
                n_total_o = 8'(1 + DATA_B);
                valid_o   = 1'b1;
            end
            default: begin
                mask_o    = '0;
                n_total_o = 8'd0;
                valid_o   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/control_command_tx.sv
// Command byte-stream transmitter: latches one parallel request, packs the
// present fields MSB-first into a shift-out register and hands the bytes to
// the control unit one at a time with a one-cycle gap and a per-byte timeout.
module control_command_tx
    import control_command_tx_pkg::*;
#(
    parameter int data_width     = 16,
    parameter int n_blocks       = 256,
    parameter int instr_width    = BLOCK_INSTR_WIDTH,
    parameter int timeout_cycles = 65535
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [7:0]                  req_command,
    input  logic [$clog2(n_blocks)-1:0] req_block,
    input  logic [7:0]                  req_reg,
    input  logic [data_width-1:0]       req_data,
    input  logic [instr_width-1:0]      req_instr,
    input  logic [31:0]                 req_delay,
    output logic [7:0]                  out_byte,
    output logic                        out_valid,
    input  logic                        out_next,
    output logic                        busy,
    output logic                        done,
    output logic                        error
);

    localparam int BLK_W = $clog2(n_blocks);
    localparam int SR_W  = 24 + data_width + instr_width + 32;
    localparam int TO_W  = $clog2(timeout_cycles + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(timeout_cycles - 1);

    tx_state_e         state_q;
    logic              out_valid_q;
    logic              done_q;
    logic              error_q;
    logic [7:0]        out_byte_q;
    logic [7:0]        idx_q;
    logic [7:0]        n_total_q;
    logic [TO_W-1:0]   cnt_q;

    logic [7:0]             cmd_q;
    logic [BLK_W-1:0]       blk_q;
    logic [7:0]             reg_q;
    logic [data_width-1:0]  data_q;
    logic [instr_width-1:0] instr_q;
    logic [31:0]            delay_q;
    logic [SR_W-1:0]        sr_q;
    logic [SR_W-1:0]        frame_d;

    tx_mask_t   lay_mask;
    logic [7:0] lay_n_total;
    logic       lay_valid;
    logic       accept;
    logic       last_byte;

    command_frame_layout #(
        .data_width  (data_width),
        .instr_width (instr_width)
    ) u_layout (
        .command_i (cmd_q),
        .mask_o    (lay_mask),
        .n_total_o (lay_n_total),
        .valid_o   (lay_valid)
    );

    // Concatenate the present fields in frame order and left-align the result
    // so the first byte to send sits in the top byte of the shift register.
    function automatic logic [SR_W-1:0] pack_frame(
        input logic [7:0]             cmd,
        input logic [7:0]             blk,
        input logic [7:0]             rg,
        input logic [data_width-1:0]  data,
        input logic [instr_width-1:0] instr,
        input logic [31:0]            delay,
        input tx_mask_t               mask,
        input logic [7:0]             n_total
    );
        logic [SR_W-1:0] acc;
        acc = SR_W'(cmd);
        if (mask[TX_FIELD_BLOCK]) acc = (acc << 8) | SR_W'(blk);
        if (mask[TX_FIELD_REG])   acc = (acc << 8) | SR_W'(rg);
        if (mask[TX_FIELD_DATA])  acc = (acc << data_width) | SR_W'(data);
        if (mask[TX_FIELD_INSTR]) acc = (acc << instr_width) | SR_W'(instr);
        if (mask[TX_FIELD_DELAY]) acc = (acc << 32) | SR_W'(delay);
        return acc << (SR_W - 8 * int'(n_total));
    endfunction

    assign accept    = req_valid && (state_q == TX_IDLE);
    assign last_byte = (idx_q == n_total_q - 8'd1);

    // Packed frame image for the latched request, consumed in LOAD.
    always_comb begin
        frame_d = pack_frame(cmd_q, 8'(blk_q), reg_q, data_q, instr_q, delay_q,
                             lay_mask, lay_n_total);
    end

    // Request fields are captured on accept; the shift register loads in LOAD and advances in GAP.
    always_ff @(posedge clk) begin
        if (accept) begin
            cmd_q   <= req_command;
            blk_q   <= req_block;
            reg_q   <= req_reg;
            data_q  <= req_data;
            instr_q <= req_instr;
            delay_q <= req_delay;
        end
        if (state_q == TX_LOAD) begin
            sr_q <= frame_d << 8;
        end else if (state_q == TX_GAP) begin
            sr_q <= sr_q << 8;
        end
    end

    // Frame sequencing FSM with registered byte, valid and status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= TX_IDLE;
            out_valid_q <= 1'b0;
            out_byte_q  <= 8'd0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            idx_q       <= 8'd0;
            n_total_q   <= 8'd0;
            cnt_q       <= '0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                TX_IDLE: begin
                    if (req_valid) begin
                        state_q <= TX_LOAD;
                    end
                end
                TX_LOAD: begin
                    if (!lay_valid) begin
                        error_q <= 1'b1;
                        state_q <= TX_IDLE;
                    end else begin
                        out_byte_q  <= frame_d[SR_W-1 -: 8];
                        out_valid_q <= 1'b1;
                        n_total_q   <= lay_n_total;
                        idx_q       <= 8'd0;
                        cnt_q       <= '0;
                        state_q     <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (out_next) begin
                        out_valid_q <= 1'b0;
                        if (last_byte) begin
                            done_q  <= 1'b1;
                            state_q <= TX_IDLE;
                        end else begin
                            state_q <= TX_GAP;
                        end
                    end else if (cnt_q == TO_LAST) begin
                        out_valid_q <= 1'b0;
                        error_q     <= 1'b1;
                        state_q     <= TX_IDLE;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + TO_W'(1);
                    end
                end
                TX_GAP: begin
                    out_byte_q  <= sr_q[SR_W-1 -: 8];
                    out_valid_q <= 1'b1;
                    idx_q       <= idx_q + 8'd1;
                    cnt_q       <= '0;
                    state_q     <= TX_SEND;
                end
                default: begin
                    state_q     <= TX_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = (state_q == TX_IDLE);
    assign busy      = (state_q != TX_IDLE);
    assign out_byte  = out_byte_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_control_command_tx.sv
// Bench for control_command_tx: table of command frames with expected byte
// streams checked through a scoreboard queue, plus hand-written sequences
// for timeout, next-at-expiry and reset mid-frame.
module tb_control_command_tx;
    import control_command_tx_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_command;
    logic [7:0]  req_block;
    logic [7:0]  req_reg;
    logic [15:0] req_data;
    logic [31:0] req_instr;
    logic [31:0] req_delay;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_next;
    logic        busy;
    logic        done;
    logic        error;

    control_command_tx #(
        .data_width     (16),
        .n_blocks       (256),
        .instr_width    (32),
        .timeout_cycles (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_command (req_command),
        .req_block   (req_block),
        .req_reg     (req_reg),
        .req_data    (req_data),
        .req_instr   (req_instr),
        .req_delay   (req_delay),
        .out_byte    (out_byte),
        .out_valid   (out_valid),
        .out_next    (out_next),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  blk;
        logic [7:0]  rg;
        logic [15:0] data;
        logic [31:0] instr;
        logic [31:0] delay;
        int          n;
        logic [63:0] exp;
        bit          is_err;
    } vec_t;

    vec_t       vecs[11];
    logic [7:0] exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    function automatic vec_t mk(input logic [7:0] cmd, input logic [7:0] blk, input logic [7:0] rg,
                                input logic [15:0] data, input logic [31:0] instr, input logic [31:0] delay,
                                input int n, input logic [63:0] exp, input bit is_err);
        vec_t v;
        v.cmd = cmd; v.blk = blk; v.rg = rg; v.data = data;
        v.instr = instr; v.delay = delay; v.n = n; v.exp = exp; v.is_err = is_err;
        return v;
    endfunction

    task automatic drive_req(input logic [7:0] cmd, input logic [7:0] blk, input logic [7:0] rg,
                             input logic [15:0] data, input logic [31:0] instr, input logic [31:0] delay);
        req_valid = 1'b1; req_command = cmd; req_block = blk; req_reg = rg;
        req_data = data; req_instr = instr; req_delay = delay;
    endtask

    // Apply one vector, act as the consumer, compare every byte against the scoreboard.
    task automatic run_vec(input vec_t v, input int id);
        int cyc, nbytes, gap;
        bit fin, saw_done, saw_err;
        logic [7:0] want;
        cyc = 0; nbytes = 0; gap = 0; fin = 0; saw_done = 0; saw_err = 0;
        @(negedge clk);
        check($sformatf("v%0d_ready_before", id), req_ready, 1);
        drive_req(v.cmd, v.blk, v.rg, v.data, v.instr, v.delay);
        if (!v.is_err) for (int i = 0; i < v.n; i++) exp_q.push_back(v.exp[63 - 8*i -: 8]);
        @(negedge clk);
        req_valid = 1'b0;
        drive_req(~v.cmd, ~v.blk, ~v.rg, ~v.data, ~v.instr, ~v.delay);
        req_valid = 1'b0;
        check($sformatf("v%0d_busy_load", id), busy, 1);
        while (!fin && cyc < 40) begin
            @(negedge clk);
            cyc++;
            out_next = 1'b0;
            if (done)  begin saw_done = 1; fin = 1; end
            if (error) begin saw_err = 1; fin = 1; end
            if (out_valid) begin
                if (nbytes == 0) check($sformatf("v%0d_first_latency", id), cyc, 1);
                else             check($sformatf("v%0d_gap%0d", id, nbytes), gap, 1);
                if (exp_q.size() > 0) begin
                    want = exp_q.pop_front();
                    check($sformatf("v%0d_byte%0d", id, nbytes), out_byte, want);
                end else begin
                    n_checks++;
                    $display("FAIL v%0d_extra_byte: got %0h, required no byte", id, out_byte);
                end
                nbytes++; gap = 0; out_next = 1'b1;
            end else if (nbytes > 0) begin
                gap++;
            end
        end
        out_next = 1'b0;
        if (!fin) begin
            n_checks++;
            $display("FAIL v%0d_timeout: got no done/error, required one within 40 cycles", id);
        end else begin
            check($sformatf("v%0d_done", id), saw_done, !v.is_err);
            check($sformatf("v%0d_error", id), saw_err, v.is_err);
            check($sformatf("v%0d_nbytes", id), nbytes, v.is_err ? 0 : v.n);
            check($sformatf("v%0d_sb_left", id), exp_q.size(), 0);
            check($sformatf("v%0d_ready_at_end", id), req_ready, 1);
            if (v.is_err) check($sformatf("v%0d_err_latency", id), cyc, 1);
        end
        exp_q.delete();
        @(negedge clk);
        check($sformatf("v%0d_pulse_single", id), {done, error}, 2'b00);
        check($sformatf("v%0d_busy_after", id), busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  vc;
        int  nb;
        bit  sd, se, hit, sv;
        reset = 1'b0; req_valid = 1'b0; out_next = 1'b0;
        drive_req(8'h0, 8'h0, 8'h0, 16'h0, 32'h0, 32'h0);
        req_valid = 1'b0;

        vecs[0]  = mk(COMMAND_COMMIT_REG_UPDATES, 8'h55, 8'h66, 16'h7777, 32'h88888888, 32'h99999999,
                      1, {COMMAND_COMMIT_REG_UPDATES, 56'h0}, 0);
        vecs[1]  = mk(COMMAND_WRITE_BLOCK_REG, 8'h03, 8'h01, 16'hBEEF, 32'h11111111, 32'h22222222,
                      5, {COMMAND_WRITE_BLOCK_REG, 8'h03, 8'h01, 8'hBE, 8'hEF, 24'h0}, 0);
        vecs[2]  = mk(COMMAND_ALLOC_DELAY, 8'hAA, 8'hBB, 16'h0004, 32'hCCCCCCCC, 32'h00012345,
                      7, {COMMAND_ALLOC_DELAY, 8'h00, 8'h04, 8'h00, 8'h01, 8'h23, 8'h45, 8'h0}, 0);
        vecs[3]  = mk(COMMAND_WRITE_BLOCK_INSTR, 8'h7A, 8'h44, 16'h5555, 32'hDEADBEEF, 32'h66666666,
                      6, {COMMAND_WRITE_BLOCK_INSTR, 8'h7A, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 16'h0}, 0);
        vecs[4]  = mk(COMMAND_UPDATE_BLOCK_REG, 8'hFF, 8'h80, 16'h1234, 32'h0, 32'h0,
                      5, {COMMAND_UPDATE_BLOCK_REG, 8'hFF, 8'h80, 8'h12, 8'h34, 24'h0}, 0);
        vecs[5]  = mk(COMMAND_SET_INPUT_GAIN, 8'h01, 8'h02, 16'h8001, 32'h3, 32'h4,
                      3, {COMMAND_SET_INPUT_GAIN, 8'h80, 8'h01, 40'h0}, 0);
        vecs[6]  = mk(COMMAND_SET_OUTPUT_GAIN, 8'h09, 8'h08, 16'h007F, 32'h7, 32'h6,
                      3, {COMMAND_SET_OUTPUT_GAIN, 8'h00, 8'h7F, 40'h0}, 0);
        vecs[7]  = mk(COMMAND_SWAP_PIPELINES, 8'h12, 8'h34, 16'h5678, 32'h9ABCDEF0, 32'h1,
                      1, {COMMAND_SWAP_PIPELINES, 56'h0}, 0);
        vecs[8]  = mk(COMMAND_RESET_PIPELINE, 8'h00, 8'h00, 16'hFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                      1, {COMMAND_RESET_PIPELINE, 56'h0}, 0);
        vecs[9]  = mk(8'hFF, 8'h01, 8'h02, 16'h0304, 32'h05060708, 32'h0,
                      0, 64'h0, 1);
        vecs[10] = mk(8'h00, 8'h01, 8'h02, 16'h0304, 32'h05060708, 32'h0,
                      0, 64'h0, 1);

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_byte", out_byte, 0);
        check("rst_status", {busy, done, error}, 3'b000);
        reset = 1'b1;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_busy_after", busy, 0);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Timeout: no consume strobe at all
        @(negedge clk);
        drive_req(COMMAND_COMMIT_REG_UPDATES, 8'h0, 8'h0, 16'h0, 32'h0, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        vc = 0; sd = 0; se = 0;
        for (int c = 0; c < 20 && !se; c++) begin
            @(negedge clk);
            if (done) sd = 1;
            if (error) se = 1;
            else if (out_valid) vc++;
        end
        check("to_error", se, 1);
        check("to_send_cycles", vc, 8);
        check("to_no_done", sd, 0);
        check("to_valid_low", out_valid, 0);
        check("to_idle", {busy, req_ready}, 2'b01);

        // Consume strobe on the expiry cycle wins over the timeout
        @(negedge clk);
        drive_req(COMMAND_SWAP_PIPELINES, 8'h0, 8'h0, 16'h0, 32'h0, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        vc = 0; sd = 0; se = 0;
        for (int c = 0; c < 20 && !(sd || se); c++) begin
            @(negedge clk);
            out_next = 1'b0;
            if (done) sd = 1;
            if (error) se = 1;
            if (out_valid) begin
                vc++;
                if (vc == 8) out_next = 1'b1;
            end
        end
        out_next = 1'b0;
        check("exp_next_done", sd, 1);
        check("exp_next_no_error", se, 0);
        check("exp_next_valid_cycles", vc, 8);

        // Reset during the third byte of an instruction write
        @(negedge clk);
        drive_req(COMMAND_WRITE_BLOCK_INSTR, 8'h11, 8'h0, 16'h0, 32'hCAFEF00D, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        nb = 0; hit = 0;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(negedge clk);
            out_next = 1'b0;
            if (out_valid) begin
                if (nb == 2) begin
                    check("rst_mid_byte3", out_byte, 8'hCA);
                    #2 reset = 1'b0;
                    #1;
                    check("rst_mid_valid_async", out_valid, 0);
                    check("rst_mid_busy", busy, 0);
                    hit = 1;
                end else begin
                    nb++;
                    out_next = 1'b1;
                end
            end
        end
        out_next = 1'b0;
        if (!hit) begin
            n_checks++;
            $display("FAIL rst_mid_reach: got %0d bytes, required third byte", nb);
        end
        @(negedge clk);
        reset = 1'b1;
        sd = 0; sv = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done) sd = 1;
            if (out_valid) sv = 1;
        end
        check("rst_mid_no_done", sd, 0);
        check("rst_mid_no_valid", sv, 0);
        check("rst_mid_ready", req_ready, 1);

        // Two frames in a row after the abandoned one
        run_vec(vecs[1], 11);
        run_vec(vecs[2], 12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
